// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared FSM state type and Wishbone cycle-type codes for the burst master.
package wb_master_pkg;
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;
endpackage

// File: rtl/wb_beat_counter.sv
// wb_beat_counter: remaining-beat counter with last-beat flag; a zero length loads as one beat.
module wb_beat_counter #(
  parameter int bl = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [bl-1:0] len,
  input  logic          dec,
  output logic          last
);
  logic [bl-1:0] remaining;
  always_ff @(posedge clk) begin
    if (rst) remaining <= '0;
    else if (load) remaining <= (len == '0) ? bl'(1) : len;
    else if (dec) remaining <= remaining - bl'(1);
  end
  assign last = remaining == bl'(1);
endmodule

// File: rtl/wb_burst_master.sv
// wb_burst_master: incrementing-burst Wishbone master with write/read beat streams.
// Optional ack timeout with sticky err flag when WB_MASTER_TIMEOUT_EN is defined.
module wb_burst_master
  import wb_master_pkg::*;
#(
  parameter int APP_AW = 26,
  parameter int dw     = 32,
  parameter int bl     = 9,
  parameter int TO_CYC = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [APP_AW-1:0] req_addr,
  input  logic [bl-1:0]     req_len,
  input  logic              req_we,
  input  logic [dw-1:0]     wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [dw-1:0]     rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [dw-1:0]     wb_dat_o,
  output logic [dw/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [dw-1:0]     wb_dat_i
`ifdef WB_MASTER_TIMEOUT_EN
  ,
  output logic              err
`endif
);
  state_t state, state_n;
  logic [APP_AW-1:0] addr;
  logic we, rdy, last, beat, accept, abort;
  assign accept = req_valid & req_ready;
  assign beat   = wb_ack_i & wb_stb_o;
  wb_beat_counter #(.bl(bl)) u_cnt (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .load(accept),
    .len (req_len),
    .dec (beat),
    .last(last)
  );
  always_ff @(posedge wb_clk_i) state <= wb_rst_i ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && accept) ? BURST :
              (state == BURST && ((beat && last) || abort)) ? DONE :
              (state == DONE) ? IDLE : state;
  end
  // rdy holds req_ready low for the first cycle after reset releases
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rdy      <= 1'b0;
      addr     <= '0;
      we       <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rdy      <= 1'b1;
      rd_valid <= beat & ~we;
      if (beat && !we) rd_data <= wb_dat_i;
      if (accept) begin
        addr <= req_addr;
        we   <= req_we;
      end else if (beat) addr <= addr + APP_AW'(dw / 8);
    end
  end
  assign req_ready = (state == IDLE) && rdy;
  assign wb_cyc_o  = state == BURST;
  assign wb_stb_o  = wb_cyc_o & (~we | wr_valid);
  assign wb_we_o   = wb_cyc_o & we;
  assign wb_sel_o  = {(dw / 8){wb_cyc_o}};
  assign wb_cti_o  = !wb_cyc_o ? CTI_CLASSIC : last ? CTI_END : CTI_INCR;
  assign wb_addr_o = addr;
  assign wb_dat_o  = wb_we_o ? wr_data : '0;
  assign wr_ready  = beat & we;
  assign done      = state == DONE;
`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] tcnt;
  // abort on the cycle the count would reach TO_CYC, so cyc stays up exactly TO_CYC cycles
  assign abort = wb_cyc_o && !beat && tcnt == TW'(TO_CYC - 1);
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (accept || beat) tcnt <= '0;
      else if (wb_cyc_o) tcnt <= tcnt + TW'(1);
      if (accept) err <= 1'b0;
      else if (abort) err <= 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif
endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: vector table plus random bursts checked against a per-beat address/cti model.
module tb_wb_burst_master;
  logic        wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [25:0] req_addr = '0;
  logic [8:0]  req_len = '0;
  logic [31:0] wr_data = '0, rd_data, wb_dat_o, wb_dat_i = '0;
  logic        wr_valid = 1'b0, wr_ready, rd_valid, done;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i = 1'b0;
  logic [25:0] wb_addr_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
`ifdef WB_MASTER_TIMEOUT_EN
  logic        err;
  int          cnt;
`endif
  int errors = 0, checks = 0;

  typedef struct {
    logic [25:0] addr;
    logic [8:0]  len;
    logic        we;
    int          ack_p;
    int          val_p;
    logic [31:0] ack_m;
    logic [31:0] val_m;
  } vec_t;
  vec_t vecs[13];
  vec_t rv;

  wb_burst_master #(.TO_CYC(16)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_len  (req_len),
    .req_we   (req_we),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .done     (done),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_addr_o(wb_addr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_cti_o (wb_cti_o),
    .wb_ack_i (wb_ack_i),
    .wb_dat_i (wb_dat_i)
`ifdef WB_MASTER_TIMEOUT_EN
    ,
    .err      (err)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  function automatic logic [68:0] snap(input logic dat_en);
    return {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_addr_o,
            dat_en ? wb_dat_o : 32'h0, wr_ready};
  endfunction

  function automatic logic pick(input int p, input logic [31:0] m, input int c);
    return (p < 0) ? ((c < 32) ? m[c] : 1'b1) : (int'($urandom_range(99)) < p);
  endfunction

  // Presents one request while idle (with a stray ack that must be ignored).
  task automatic request(input vec_t v);
    req_valid = 1'b1; req_addr = v.addr; req_len = v.len; req_we = v.we;
    wb_ack_i = 1'b1; wr_valid = 1'b0;
    #1;
    check("req_ready", req_ready, 1);
    check("idle_cyc", wb_cyc_o, 0);
    tick();
    req_valid = 1'b0; req_addr = 26'($urandom); req_len = 9'($urandom); req_we = ~v.we;
  endtask

  // Beat i of a burst must show address base+4i (mod 2^26) and INCR until one beat remains.
  task automatic run_burst(input vec_t v);
    int n, i, c, wrr;
    logic pv, st, ak;
    logic [31:0] pd;
    logic [25:0] ea;
    logic [2:0] ecti;
    n = (v.len == 0) ? 1 : int'(v.len);
    i = 0; c = 0; wrr = 0; pv = 1'b0; pd = '0;
    request(v);
    while (i < n && c < 300) begin
      ak = pick(v.ack_p, v.ack_m, c);
      wr_valid = pick(v.val_p, v.val_m, c);
      wr_data = $urandom; wb_dat_i = $urandom; wb_ack_i = ak;
      #1;
      st = v.we ? wr_valid : 1'b1;
      ea = v.addr + 26'(i * 4);
      ecti = (n - i > 1) ? 3'b010 : 3'b111;
      check("beat", snap(v.we), {1'b1, st, v.we, 4'hF, ecti, ea, v.we ? wr_data : 32'h0, v.we & ak & st});
      check("rd_valid", rd_valid, pv);
      if (pv) check("rd_data", rd_data, pd);
      pv = ak & st & ~v.we;
      pd = wb_dat_i;
      wrr += int'(wr_ready);
      if (ak & st) i++;
      c++;
      tick();
    end
    if (c >= 300) begin
      checks++; errors++;
      $display("FAIL burst_budget: got %0d beats expected %0d", i, n);
    end
    wb_ack_i = 1'b1; wr_valid = 1'b1;
    #1;
    check("done_cycle", {done, wb_cyc_o, wb_stb_o, req_ready, wr_ready, rd_valid}, {5'b10000, pv});
    if (pv) check("rd_data_last", rd_data, pd);
    check("wr_ready_count", wrr, v.we ? n : 0);
    wb_ack_i = 1'b0; wr_valid = 1'b0;
    tick();
    #1;
    check("after_done", {done, wb_cyc_o, rd_valid, req_ready}, 4'b0001);
  endtask

  initial begin
    vecs[0] = '{26'h100, 9'd4, 1'b1, 100, 100, 32'h0, 32'h0};
    vecs[1] = '{26'h40, 9'd1, 1'b0, -1, 100, 32'h8, 32'h0};
    vecs[2] = '{26'h200, 9'd3, 1'b1, 100, -1, 32'h0, ~32'h6};
    vecs[3] = '{26'h3FFFFFC, 9'd2, 1'b0, 100, 100, 32'h0, 32'h0};
    vecs[4] = '{26'h80, 9'd0, 1'b1, 100, 100, 32'h0, 32'h0};
    for (int k = 5; k < 13; k++)
      vecs[k] = '{26'($urandom) & ~26'h3, 9'(1 + $urandom_range(11)), 1'($urandom),
                  30 + int'($urandom_range(70)), 30 + int'($urandom_range(70)), 32'h0, 32'h0};
    vecs[12].addr = 26'h3FFFFF0;

    tick();
    tick();
    check("reset_state", {snap(1'b1), rd_valid, done, req_ready}, '0);
    wb_rst_i = 1'b0;
    tick();
    check("ready_after_reset", req_ready, 1);

    for (int k = 0; k < 13; k++) run_burst(vecs[k]);

    rv = '{26'h500, 9'd8, 1'b0, 100, 100, 32'h0, 32'h0};
    request(rv);
    wb_ack_i = 1'b1;
    tick();
    tick();
    wb_rst_i = 1'b1;
    tick();
    check("reset_mid_burst", {snap(1'b1), rd_valid, done, req_ready}, '0);
    wb_rst_i = 1'b0; wb_ack_i = 1'b0;
    tick();
    check("ready_after_release", {req_ready, done, wb_cyc_o}, 3'b100);
    run_burst(vecs[3]);

`ifdef WB_MASTER_TIMEOUT_EN
    rv = '{26'h600, 9'd2, 1'b0, 0, 100, 32'h0, 32'h0};
    request(rv);
    wb_ack_i = 1'b0;
    cnt = 0;
    while (cnt < 40) begin
      #1;
      if (!wb_cyc_o) break;
      cnt++;
      tick();
    end
    check("timeout_cycles", cnt, 16);
    check("timeout_flags", {done, err}, 2'b11);
    tick();
    check("err_sticky", {err, req_ready, done}, 3'b110);
    run_burst(vecs[0]);
    check("err_cleared", err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
